// File: rtl/pkg_dtypes.sv
// -----------------------------------------------------------------------------
// pkg_dtypes
// Shared datatypes for the ALU operand cache slice.
//   WORD_WIDTH       : operand word width (from the `WORD_WIDTH macro)
//   DEF_ADDR_WIDTH   : default operand address width
//   type_alu_channel_rx : cache -> ALU (operand read data, store acknowledge)
//   type_alu_channel_tx : ALU -> cache (destination operand store)
//   type_opd_fsm_state  : eviction control states
// -----------------------------------------------------------------------------
`ifndef WORD_WIDTH
`define WORD_WIDTH 16
`endif

package pkg_dtypes;

    localparam int WORD_WIDTH     = `WORD_WIDTH;
    localparam int DEF_ADDR_WIDTH = 8;

    typedef struct packed {
        logic                      op0_valid;
        logic [WORD_WIDTH-1:0]     op0_data;
        logic                      op1_valid;
        logic [WORD_WIDTH-1:0]     op1_data;
        logic [DEF_ADDR_WIDTH-1:0] opd_addr;
        logic                      opd_store_success;
    } type_alu_channel_rx;

    typedef struct packed {
        logic                      opd_valid;
        logic [DEF_ADDR_WIDTH-1:0] opd_addr;
        logic [WORD_WIDTH-1:0]     opd_data;
    } type_alu_channel_tx;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_EVICT = 1'b1
    } type_opd_fsm_state;

endpackage

// File: rtl/opd_cache_victim_sel.sv
// -----------------------------------------------------------------------------
// opd_cache_victim_sel
// Combinational round-robin victim search over a full cache.
//   ptr         : round-robin start index
//   entry_addr  : address of every entry (all entries are valid when used)
//   req_valid   : current instruction valid, enables operand protection
//   op0_addr/op1_addr : operand addresses that must not be evicted
//   victim_idx  : chosen entry index
// -----------------------------------------------------------------------------
module opd_cache_victim_sel
    import pkg_dtypes::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int NUM_ENTRIES = 8
) (
    input  logic [$clog2(NUM_ENTRIES)-1:0]          ptr,
    input  logic [NUM_ENTRIES-1:0][ADDR_WIDTH-1:0]  entry_addr,
    input  logic                                    req_valid,
    input  logic [ADDR_WIDTH-1:0]                   op0_addr,
    input  logic [ADDR_WIDTH-1:0]                   op1_addr,
    output logic [$clog2(NUM_ENTRIES)-1:0]          victim_idx
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);

    logic [IDX_W-1:0] scan_idx_s;
    logic [IDX_W-1:0] rr_idx_s;
    logic             rr_found_s;
    logic [IDX_W-1:0] fb_idx_s;
    logic             protect_s;

    // Round-robin scan from ptr; scanning the offsets downward lets the
    // smallest offset win. Fallback is the lowest entry not holding op0.
    always_comb begin
        scan_idx_s = '0;
        rr_idx_s   = '0;
        rr_found_s = 1'b0;
        fb_idx_s   = '0;
        protect_s  = 1'b0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            fb_idx_s = (entry_addr[i] != op0_addr) ? IDX_W'(i) : fb_idx_s;
        end
        for (int k = NUM_ENTRIES - 1; k >= 0; k--) begin
            // Index arithmetic wraps modulo NUM_ENTRIES (power of two).
            scan_idx_s = ptr + IDX_W'(k);
            protect_s  = req_valid && ((entry_addr[scan_idx_s] == op0_addr) ||
                                       (entry_addr[scan_idx_s] == op1_addr));
            rr_idx_s   = protect_s ? rr_idx_s : scan_idx_s;
            rr_found_s = rr_found_s | ~protect_s;
        end
        victim_idx = rr_found_s ? rr_idx_s : fb_idx_s;
    end

endmodule

// File: rtl/alu_opd_cache.sv
// -----------------------------------------------------------------------------
// alu_opd_cache
// Fully associative operand cache between the ALU and the interconnect.
//   clk, reset        : clock, synchronous active-high reset
//   alu_rx_o          : op0/op1 read data+valid, opd_addr echo, store success
//   alu_tx_i          : destination operand store from the ALU
//   req_*             : current instruction operand/destination addresses
//   fill_*            : operand fill from interconnect (valid/ready)
//   evict_*           : victim writeback to interconnect (valid/ready)
// -----------------------------------------------------------------------------
`ifndef WORD_WIDTH
`define WORD_WIDTH 16
`endif

module alu_opd_cache
    import pkg_dtypes::*;
#(
    parameter int DATA_WIDTH  = `WORD_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int NUM_ENTRIES = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    output type_alu_channel_rx     alu_rx_o,
    input  type_alu_channel_tx     alu_tx_i,
    input  logic                   req_valid_i,
    input  logic [ADDR_WIDTH-1:0]  req_op0_addr_i,
    input  logic [ADDR_WIDTH-1:0]  req_op1_addr_i,
    input  logic [ADDR_WIDTH-1:0]  req_opd_addr_i,
    input  logic                   fill_valid_i,
    input  logic [ADDR_WIDTH-1:0]  fill_addr_i,
    input  logic [DATA_WIDTH-1:0]  fill_data_i,
    output logic                   fill_ready_o,
    output logic                   evict_valid_o,
    output logic [ADDR_WIDTH-1:0]  evict_addr_o,
    output logic [DATA_WIDTH-1:0]  evict_data_o,
    input  logic                   evict_ready_i
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);

    logic [NUM_ENTRIES-1:0]                 valid_r;
    logic [NUM_ENTRIES-1:0][ADDR_WIDTH-1:0] addr_r;
    logic [NUM_ENTRIES-1:0][DATA_WIDTH-1:0] data_r;
    type_opd_fsm_state                      state_r;
    logic [IDX_W-1:0]                       ptr_r;
    logic [IDX_W-1:0]                       victim_idx_r;
    logic [ADDR_WIDTH-1:0]                  victim_addr_r;
    logic [DATA_WIDTH-1:0]                  victim_data_r;

    logic                  op0_hit_s, op1_hit_s;
    logic [DATA_WIDTH-1:0] op0_data_s, op1_data_s;
    logic                  st_hit_s, fill_hit_s, free_s;
    logic [IDX_W-1:0]      st_hit_idx_s, fill_hit_idx_s, free_idx_s;
    logic [IDX_W-1:0]      st_idx_s, fill_idx_s, victim_idx_s;
    logic                  in_evict_s, st_ok_s, evict_start_s, fill_ready_s;
    logic                  fill_take_s, evict_done_s;

    // Tag lookups: operand reads, store/fill address match, lowest free slot.
    // Addresses are unique among valid entries, so OR-merging read data is safe.
    always_comb begin
        op0_hit_s      = 1'b0;
        op1_hit_s      = 1'b0;
        op0_data_s     = '0;
        op1_data_s     = '0;
        st_hit_s       = 1'b0;
        fill_hit_s     = 1'b0;
        free_s         = 1'b0;
        st_hit_idx_s   = '0;
        fill_hit_idx_s = '0;
        free_idx_s     = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            op0_hit_s  = op0_hit_s | (valid_r[i] && (addr_r[i] == req_op0_addr_i));
            op1_hit_s  = op1_hit_s | (valid_r[i] && (addr_r[i] == req_op1_addr_i));
            op0_data_s = op0_data_s | ((valid_r[i] && (addr_r[i] == req_op0_addr_i)) ? data_r[i] : '0);
            op1_data_s = op1_data_s | ((valid_r[i] && (addr_r[i] == req_op1_addr_i)) ? data_r[i] : '0);
            st_hit_idx_s   = (valid_r[i] && (addr_r[i] == alu_tx_i.opd_addr)) ? IDX_W'(i) : st_hit_idx_s;
            st_hit_s       = st_hit_s | (valid_r[i] && (addr_r[i] == alu_tx_i.opd_addr));
            fill_hit_idx_s = (valid_r[i] && (addr_r[i] == fill_addr_i)) ? IDX_W'(i) : fill_hit_idx_s;
            fill_hit_s     = fill_hit_s | (valid_r[i] && (addr_r[i] == fill_addr_i));
            free_idx_s     = (!valid_r[i]) ? IDX_W'(i) : free_idx_s;
            free_s         = free_s | ~valid_r[i];
        end
    end

    // Store/fill arbitration; a store or fill to the victim being written back
    // stalls until the handshake completes (fill is simply held off in EVICT).
    always_comb begin
        in_evict_s    = (state_r == ST_EVICT);
        st_idx_s      = st_hit_s ? st_hit_idx_s : free_idx_s;
        fill_idx_s    = fill_hit_s ? fill_hit_idx_s : free_idx_s;
        st_ok_s       = alu_tx_i.opd_valid &&
                        !(in_evict_s && (alu_tx_i.opd_addr == victim_addr_r)) &&
                        (st_hit_s || free_s);
        evict_start_s = alu_tx_i.opd_valid && !in_evict_s && !st_hit_s && !free_s;
        fill_ready_s  = !alu_tx_i.opd_valid && !in_evict_s && (fill_hit_s || free_s);
        fill_take_s   = fill_valid_i && fill_ready_s;
        evict_done_s  = in_evict_s && evict_ready_i;
    end

    opd_cache_victim_sel #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .NUM_ENTRIES (NUM_ENTRIES)
    ) u_victim_sel (
        .ptr        (ptr_r),
        .entry_addr (addr_r),
        .req_valid  (req_valid_i),
        .op0_addr   (req_op0_addr_i),
        .op1_addr   (req_op1_addr_i),
        .victim_idx (victim_idx_s)
    );

    // ALU-facing outputs are combinational views of the registered entries.
    always_comb begin
        alu_rx_o.op0_valid         = req_valid_i && op0_hit_s;
        alu_rx_o.op0_data          = (req_valid_i && op0_hit_s) ? op0_data_s : '0;
        alu_rx_o.op1_valid         = req_valid_i && op1_hit_s;
        alu_rx_o.op1_data          = (req_valid_i && op1_hit_s) ? op1_data_s : '0;
        alu_rx_o.opd_addr          = req_opd_addr_i;
        alu_rx_o.opd_store_success = st_ok_s;
        fill_ready_o               = fill_ready_s;
        evict_valid_o              = in_evict_s;
        evict_addr_o               = victim_addr_r;
        evict_data_o               = victim_data_r;
    end

    // Entry storage, eviction FSM and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r       <= '0;
            state_r       <= ST_IDLE;
            ptr_r         <= '0;
            victim_idx_r  <= '0;
            victim_addr_r <= '0;
            victim_data_r <= '0;
        end else begin
            if (st_ok_s) begin
                valid_r[st_idx_s] <= 1'b1;
                addr_r[st_idx_s]  <= alu_tx_i.opd_addr;
                data_r[st_idx_s]  <= alu_tx_i.opd_data;
            end
            if (fill_take_s) begin
                valid_r[fill_idx_s] <= 1'b1;
                addr_r[fill_idx_s]  <= fill_addr_i;
                data_r[fill_idx_s]  <= fill_data_i;
            end
            case (state_r)
                ST_IDLE: begin
                    if (evict_start_s) begin
                        state_r       <= ST_EVICT;
                        victim_idx_r  <= victim_idx_s;
                        victim_addr_r <= addr_r[victim_idx_s];
                        victim_data_r <= data_r[victim_idx_s];
                    end
                end
                ST_EVICT: begin
                    if (evict_done_s) begin
                        valid_r[victim_idx_r] <= 1'b0;
                        ptr_r                 <= victim_idx_r + IDX_W'(1);
                        state_r               <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_opd_cache.sv
module tb_alu_opd_cache;
    import pkg_dtypes::*;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 8;

    logic               clk = 1'b0;
    logic               reset;
    type_alu_channel_rx rx;
    type_alu_channel_tx tx;
    logic               req_valid;
    logic [AW-1:0]      op0, op1, opd;
    logic               fill_valid;
    logic [AW-1:0]      fill_addr;
    logic [DW-1:0]      fill_data;
    logic               fill_ready;
    logic               evict_valid;
    logic [AW-1:0]      evict_addr;
    logic [DW-1:0]      evict_data;
    logic               evict_ready;

    int checks_n = 0;
    int fails_n  = 0;

    always #5 clk = ~clk;

    alu_opd_cache #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_ENTRIES(N)) dut (
        .clk            (clk),
        .reset          (reset),
        .alu_rx_o       (rx),
        .alu_tx_i       (tx),
        .req_valid_i    (req_valid),
        .req_op0_addr_i (op0),
        .req_op1_addr_i (op1),
        .req_opd_addr_i (opd),
        .fill_valid_i   (fill_valid),
        .fill_addr_i    (fill_addr),
        .fill_data_i    (fill_data),
        .fill_ready_o   (fill_ready),
        .evict_valid_o  (evict_valid),
        .evict_addr_o   (evict_addr),
        .evict_data_o   (evict_data),
        .evict_ready_i  (evict_ready)
    );

    // Reference cache: slot arrays plus an outstanding-eviction record.
    bit m_v[N];
    int m_a[N];
    int m_d[N];
    bit m_ev;
    int m_vi, m_va, m_vd, m_ptr;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_n++;
        if (obs !== exp) begin
            fails_n++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    function automatic int m_find(input int a);
        for (int i = 0; i < N; i++) if (m_v[i] && m_a[i] == a) return i;
        return -1;
    endfunction

    function automatic int m_free();
        for (int i = 0; i < N; i++) if (!m_v[i]) return i;
        return -1;
    endfunction

    function automatic int m_rd(input int idx);
        if (idx < 0) return 0;
        return m_d[idx];
    endfunction

    function automatic bit m_store_ok();
        if (!tx.opd_valid) return 1'b0;
        if (m_ev && int'(tx.opd_addr) == m_va) return 1'b0;
        return (m_find(int'(tx.opd_addr)) >= 0) || (m_free() >= 0);
    endfunction

    function automatic bit m_fill_ready();
        if (tx.opd_valid || m_ev) return 1'b0;
        return (m_find(int'(fill_addr)) >= 0) || (m_free() >= 0);
    endfunction

    function automatic int m_pick_victim();
        for (int k = 0; k < N; k++) begin
            int i = (m_ptr + k) % N;
            if (!(req_valid && (m_a[i] == int'(op0) || m_a[i] == int'(op1)))) return i;
        end
        for (int i = 0; i < N; i++) if (m_a[i] != int'(op0)) return i;
        return 0;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < N; i++) m_v[i] = 1'b0;
        m_ev  = 1'b0;
        m_ptr = 0;
    endtask

    task automatic model_check();
        int i0, i1;
        i0 = req_valid ? m_find(int'(op0)) : -1;
        i1 = req_valid ? m_find(int'(op1)) : -1;
        check_val("op0_valid", rx.op0_valid, i0 >= 0);
        check_val("op0_data", rx.op0_data, m_rd(i0));
        check_val("op1_valid", rx.op1_valid, i1 >= 0);
        check_val("op1_data", rx.op1_data, m_rd(i1));
        check_val("opd_addr", rx.opd_addr, opd);
        check_val("store_success", rx.opd_store_success, m_store_ok());
        check_val("fill_ready", fill_ready, m_fill_ready());
        check_val("evict_valid", evict_valid, m_ev);
        if (m_ev) begin
            check_val("evict_addr", evict_addr, m_va);
            check_val("evict_data", evict_data, m_vd);
        end
    endtask

    task automatic model_update();
        int si, fi, vi;
        bit st_ok, fr, hs, start;
        if (reset) begin
            m_clear();
            return;
        end
        st_ok = m_store_ok();
        fr    = m_fill_ready();
        hs    = m_ev && evict_ready;
        start = tx.opd_valid && !st_ok && !m_ev;
        si = m_find(int'(tx.opd_addr));
        if (si < 0) si = m_free();
        fi = m_find(int'(fill_addr));
        if (fi < 0) fi = m_free();
        vi = start ? m_pick_victim() : 0;
        if (st_ok) begin
            m_v[si] = 1'b1; m_a[si] = int'(tx.opd_addr); m_d[si] = int'(tx.opd_data);
        end
        if (fill_valid && fr) begin
            m_v[fi] = 1'b1; m_a[fi] = int'(fill_addr); m_d[fi] = int'(fill_data);
        end
        if (hs) begin
            m_v[m_vi] = 1'b0;
            m_ptr     = (m_vi + 1) % N;
            m_ev      = 1'b0;
        end
        if (start) begin
            m_ev = 1'b1; m_vi = vi; m_va = m_a[vi]; m_vd = m_d[vi];
        end
    endtask

    // One clock: compare outputs for the applied inputs, advance model, move to next negedge.
    task automatic tick();
        #1;
        model_check();
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_in();
        req_valid = 1'b0; op0 = '0; op1 = '0; opd = '0;
        tx = '0;
        fill_valid = 1'b0; fill_addr = '0; fill_data = '0;
        evict_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_in();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic fill(input int a, input int d);
        fill_valid = 1'b1; fill_addr = AW'(a); fill_data = DW'(d);
        tick();
        fill_valid = 1'b0;
    endtask

    task automatic fill_four();
        for (int a = 1; a <= 4; a++) fill(a, 16'h0100 + a);
    endtask

    task automatic store(input int a, input int d);
        tx.opd_valid = 1'b1; tx.opd_addr = AW'(a); tx.opd_data = DW'(d);
    endtask

    initial begin
        idle_in();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        m_clear();
        reset = 1'b0;

        // Reset state
        req_valid = 1'b1;
        #1;
        check_val("rst_op0_valid", rx.op0_valid, 1'b0);
        check_val("rst_evict_valid", evict_valid, 1'b0);
        check_val("rst_fill_ready", fill_ready, 1'b1);
        check_val("rst_store_success", rx.opd_store_success, 1'b0);
        tick();

        // Fill then read both operands
        fill(3, 16'h00AA);
        req_valid = 1'b1; op0 = 8'd3; op1 = 8'd3;
        #1;
        check_val("fill_rd_op0_valid", rx.op0_valid, 1'b1);
        check_val("fill_rd_op0_data", rx.op0_data, 16'h00AA);
        check_val("fill_rd_op1_data", rx.op1_data, 16'h00AA);
        tick();

        // Store into empty cache
        do_reset();
        store(5, 16'h1234);
        #1;
        check_val("store_empty_success", rx.opd_store_success, 1'b1);
        tick();
        tx.opd_valid = 1'b0; req_valid = 1'b1; op0 = 8'd5;
        #1;
        check_val("store_empty_rd", rx.op0_data, 16'h1234);
        tick();

        // Full cache store with protected operands -> evict addr 3
        do_reset();
        fill_four();
        req_valid = 1'b1; op0 = 8'd1; op1 = 8'd2;
        store(9, 16'h9999);
        #1;
        check_val("full_store_success", rx.opd_store_success, 1'b0);
        tick();
        #1;
        check_val("evict_valid_up", evict_valid, 1'b1);
        check_val("evict_victim_addr", evict_addr, 8'd3);
        check_val("evict_victim_data", evict_data, 16'h0103);
        tick();
        tick();
        evict_ready = 1'b1;
        tick();
        evict_ready = 1'b0;
        #1;
        check_val("post_evict_success", rx.opd_store_success, 1'b1);
        tick();
        tx.opd_valid = 1'b0; op0 = 8'd9; op1 = 8'd3;
        #1;
        check_val("new_addr_resident", rx.op0_valid, 1'b1);
        check_val("new_addr_data", rx.op0_data, 16'h9999);
        check_val("victim_absent", rx.op1_valid, 1'b0);
        tick();

        // Store beats fill; fill waits for an eviction
        do_reset();
        fill(1, 16'h0011); fill(2, 16'h0022); fill(3, 16'h0033);
        store(7, 16'h0777);
        fill_valid = 1'b1; fill_addr = 8'd8; fill_data = 16'h0888;
        #1;
        check_val("prio_store_success", rx.opd_store_success, 1'b1);
        check_val("prio_fill_stalled", fill_ready, 1'b0);
        tick();
        tx.opd_addr = 8'd10;
        tick();
        evict_ready = 1'b1;
        #1;
        check_val("prio_evict_addr", evict_addr, 8'd1);
        tick();
        evict_ready = 1'b0; tx.opd_valid = 1'b0;
        #1;
        check_val("prio_fill_ready", fill_ready, 1'b1);
        tick();
        fill_valid = 1'b0; req_valid = 1'b1; op0 = 8'd8; op1 = 8'd7;
        #1;
        check_val("prio_fill_data", rx.op0_data, 16'h0888);
        check_val("prio_store_data", rx.op1_data, 16'h0777);
        tick();

        // Reset during eviction abandons it
        do_reset();
        fill_four();
        store(9, 16'h0009);
        tick();
        tx.opd_valid = 1'b0;
        #1;
        check_val("mid_evict_valid", evict_valid, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0; req_valid = 1'b1; op0 = 8'd1; op1 = 8'd2;
        #1;
        check_val("rst_evict_dropped", evict_valid, 1'b0);
        check_val("rst_evict_op0", rx.op0_valid, 1'b0);
        check_val("rst_evict_op1", rx.op1_valid, 1'b0);
        check_val("rst_evict_fill_ready", fill_ready, 1'b1);
        tick();

        // Store to resident address in full cache
        do_reset();
        fill_four();
        store(2, 16'hBEEF);
        #1;
        check_val("resident_success", rx.opd_store_success, 1'b1);
        tick();
        tx.opd_valid = 1'b0; req_valid = 1'b1; op0 = 8'd2;
        #1;
        check_val("resident_no_evict", evict_valid, 1'b0);
        check_val("resident_data", rx.op0_data, 16'hBEEF);
        tick();

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset        = ($urandom_range(99) == 0);
            req_valid    = ($urandom_range(9) < 7);
            op0          = AW'($urandom_range(7));
            op1          = AW'($urandom_range(7));
            opd          = AW'($urandom_range(255));
            tx.opd_valid = ($urandom_range(9) < 4);
            tx.opd_addr  = AW'($urandom_range(7));
            tx.opd_data  = DW'($urandom);
            fill_valid   = ($urandom_range(1) == 1);
            fill_addr    = AW'($urandom_range(7));
            fill_data    = DW'($urandom);
            evict_ready  = ($urandom_range(1) == 1);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks_n, fails_n);
        $finish;
    end

endmodule
